// File: rtl/pipe_pkg.sv
// pipe_pkg
//   Shared types and constants for the inter-stage pipeline buffers.
//   - state_e     : occupancy state of a buffer (EMPTY / ONE / FULL)
//   - main_sel_e  : source select for the main (head) payload register
//   - NOP_INST    : bubble instruction (addi x0, x0, 0) used as a stage NOP
//   - *_BUS_W     : bus widths of the core's datapath
//   - *_W         : per-boundary payload widths built from those buses
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MAIN_KEEP = 2'd0,
    MAIN_IN   = 2'd1,
    MAIN_SKID = 2'd2,
    MAIN_NOP  = 2'd3
  } main_sel_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Datapath buses
  localparam int INST_BUS_W     = 32;
  localparam int REG_BUS_W      = 32;
  localparam int MEM_ADDR_BUS_W = 32;
  localparam int REG_ADDR_BUS_W = 5;

  // Stage payloads: instruction + pc at IF/ID, operands + destination
  // downstream, one write-enable bit where a register write is carried.
  localparam int IF_ID_W  = INST_BUS_W + MEM_ADDR_BUS_W;
  localparam int ID_EX_W  = INST_BUS_W + 2 * REG_BUS_W + REG_ADDR_BUS_W + 1;
  localparam int EX_MEM_W = REG_BUS_W + MEM_ADDR_BUS_W + REG_ADDR_BUS_W + 1;
  localparam int MEM_WB_W = REG_BUS_W + REG_ADDR_BUS_W + 1;

  // Occupancy encoded by a state.
  function automatic logic [1:0] state_count(input state_e s);
    case (s)
      ST_ONE:  return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_ctrl.sv
// pipe_skid_ctrl
//   Control half of pipe_stage_buf: occupancy state machine, fire logic,
//   handshake outputs and load selects for the payload registers.
// Ports
//   clk          in   clock
//   rst_n        in   synchronous active-low reset
//   hold_i       in   global stall, blocks push and pop
//   flush_i      in   discard all entries
//   in_valid_i   in   upstream valid
//   out_ready_i  in   downstream ready
//   in_ready_o   out  buffer can accept (flop when SKID=1)
//   out_valid_o  out  head entry valid (flop)
//   count_o      out  occupancy 0..2
//   main_sel_o   out  next source of the main payload register
//   skid_load_o  out  capture in_data into the skid register
module pipe_skid_ctrl
  import pipe_pkg::*;
#(
  parameter int SKID = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      hold_i,
  input  logic      flush_i,
  input  logic      in_valid_i,
  input  logic      out_ready_i,
  output logic      in_ready_o,
  output logic      out_valid_o,
  output logic [1:0] count_o,
  output main_sel_e main_sel_o,
  output logic      skid_load_o
);

  state_e     state_reg, state_next;
  logic       out_valid_reg;
  logic [1:0] count_reg;
  logic       in_fire, out_fire;

  assign out_fire = out_valid_reg & out_ready_i & ~hold_i;
  assign in_fire  = in_valid_i & in_ready_o & ~hold_i;

  generate
    if (SKID != 0) begin : g_skid
      // Ready comes straight from a flop so there is no path from
      // out_ready_i back to in_ready_o.
      logic in_ready_reg;
      always_ff @(posedge clk) begin
        in_ready_reg <= (state_next != ST_FULL);
      end
      assign in_ready_o = in_ready_reg;
    end else begin : g_single
      // Single entry: accept when empty or when the head leaves this cycle.
      assign in_ready_o = ~out_valid_reg | (out_ready_i & ~hold_i);
    end
  endgenerate

  // Reset and flush share one path: both force EMPTY and reload the bubble.
  // Hold needs no explicit term since it already suppresses both fires.
  always_comb begin
    state_next  = state_reg;
    main_sel_o  = MAIN_KEEP;
    skid_load_o = 1'b0;
    if (!rst_n || flush_i) begin
      state_next = ST_EMPTY;
      main_sel_o = MAIN_NOP;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (in_fire) begin
            state_next = ST_ONE;
            main_sel_o = MAIN_IN;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_sel_o = MAIN_IN;
          end else if (in_fire) begin
            // Only reachable with a skid entry; with SKID=0 an accept
            // while occupied always coincides with a pop.
            if (SKID != 0) begin
              state_next  = ST_FULL;
              skid_load_o = 1'b1;
            end
          end else if (out_fire) begin
            state_next = ST_EMPTY;
            main_sel_o = MAIN_NOP;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_next = ST_ONE;
            main_sel_o = MAIN_SKID;
          end
        end
        default: begin
          state_next = ST_EMPTY;
          main_sel_o = MAIN_NOP;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_reg     <= state_next;
    out_valid_reg <= (state_next != ST_EMPTY);
    count_reg     <= state_count(state_next);
  end

  assign out_valid_o = out_valid_reg;
  assign count_o     = count_reg;

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
//   Inter-stage pipeline buffer carrying an opaque DATA_W payload under a
//   valid/ready handshake, with global hold and flush. SKID=1 gives a
//   two-entry skid buffer with registered in_ready_o; SKID=0 a single
//   register with combinational in_ready_o.
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   hold_i       global stall
//   flush_i      pipeline kill
//   in_valid_i / in_ready_o / in_data_i     upstream handshake + payload
//   out_valid_o / out_ready_i / out_data_o  downstream handshake + payload
//   count_o      occupancy
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int               DATA_W  = 64,
  parameter int               SKID    = 1,
  parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o
);

  main_sel_e         main_sel;
  logic              skid_load;
  logic [DATA_W-1:0] main_reg, main_next;
  logic [DATA_W-1:0] skid_data;

  pipe_skid_ctrl #(
    .SKID(SKID)
  ) u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold_i     (hold_i),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .out_ready_i(out_ready_i),
    .in_ready_o (in_ready_o),
    .out_valid_o(out_valid_o),
    .count_o    (count_o),
    .main_sel_o (main_sel),
    .skid_load_o(skid_load)
  );

  generate
    if (SKID != 0) begin : g_skid
      // Contents are meaningless unless the controller is FULL, so no reset.
      logic [DATA_W-1:0] skid_reg;
      always_ff @(posedge clk) begin
        if (skid_load) begin
          skid_reg <= in_data_i;
        end
      end
      assign skid_data = skid_reg;
    end else begin : g_noskid
      assign skid_data = NOP_VAL;
    end
  endgenerate

  always_comb begin
    main_next = main_reg;
    case (main_sel)
      MAIN_IN:   main_next = in_data_i;
      MAIN_SKID: main_next = skid_data;
      MAIN_NOP:  main_next = NOP_VAL;
      default:   main_next = main_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    main_reg <= main_next;
  end

  assign out_data_o = main_reg;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf. Two instances share all inputs:
// index 1 is SKID=1 (bubble 0x13), index 0 is SKID=0 (bubble 0). Each has a
// queue model: accepted payloads are pushed at the clock edge, the monitor
// checks outputs on the falling edge and pops when the head transfers.
module tb_pipe_stage_buf;

  localparam logic [63:0] NOP1 = 64'h13;
  localparam logic [63:0] NOP0 = 64'h0;

  logic        clk = 1'b0;
  logic        rst_n, hold, flush, in_valid, out_ready;
  logic [63:0] in_data;

  logic        in_ready_w  [2];
  logic        out_valid_w [2];
  logic [63:0] out_data_w  [2];
  logic [1:0]  count_w     [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit active = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(64), .SKID(1), .NOP_VAL(NOP1)) dut_skid (
    .clk(clk), .rst_n(rst_n), .hold_i(hold), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready_w[1]), .in_data_i(in_data),
    .out_valid_o(out_valid_w[1]), .out_ready_i(out_ready),
    .out_data_o(out_data_w[1]), .count_o(count_w[1])
  );

  pipe_stage_buf #(.DATA_W(64), .SKID(0), .NOP_VAL(NOP0)) dut_reg (
    .clk(clk), .rst_n(rst_n), .hold_i(hold), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready_w[0]), .in_data_i(in_data),
    .out_valid_o(out_valid_w[0]), .out_ready_i(out_ready),
    .out_data_o(out_data_w[0]), .count_o(count_w[0])
  );

  task automatic chk(input int d, input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL dut%0d cyc %0d %s got %h exp %h", d, cyc, nm, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sb
      localparam int CAP = (gi == 1) ? 2 : 1;
      localparam logic [63:0] NOPV = (gi == 1) ? NOP1 : NOP0;
      logic [63:0] q[$];
      bit          exp_rdy;
      int          delivered = 0;

      // Monitor: compare the visible state with the model, pop on transfer.
      always @(negedge clk) begin
        if (CAP == 2) exp_rdy = (q.size() < 2);
        else          exp_rdy = (q.size() == 0) || (out_ready && !hold);
        if (active) begin
          chk(gi, "out_valid", {63'd0, out_valid_w[gi]}, {63'd0, q.size() > 0});
          chk(gi, "count", {62'd0, count_w[gi]}, 64'(q.size()));
          chk(gi, "in_ready", {63'd0, in_ready_w[gi]}, {63'd0, exp_rdy});
          chk(gi, "out_data", out_data_w[gi], (q.size() > 0) ? q[0] : NOPV);
          if (q.size() > 0 && out_ready && !hold && rst_n && !flush) begin
            $display("dut%0d cyc %0d deliver %h", gi, cyc, q[0]);
            void'(q.pop_front());
            delivered++;
          end
        end
      end

      // Stimulus side: record accepted payloads, clear on reset/flush.
      always @(posedge clk) begin
        if (!rst_n || flush) q.delete();
        else if (in_valid && exp_rdy && !hold && q.size() < CAP) q.push_back(in_data);
      end
    end
  endgenerate

  always @(posedge clk) if (!rst_n) active = 1'b1;

  task automatic step(input bit r, input bit f, input bit h, input bit v,
                      input logic [63:0] d, input bit o);
    rst_n = r; flush = f; hold = h; in_valid = v; in_data = d; out_ready = o;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(0, 0, 0, 0, 64'h0, 0);
    step(0, 0, 0, 0, 64'h0, 0);

    // Streaming 0x1..0x10 with downstream always ready
    for (int i = 1; i <= 16; i++) step(1, 0, 0, 1, 64'(i), 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 64'h0, 1);

    // Backpressure A, B, C then release
    step(1, 0, 0, 1, 64'hA, 0);
    step(1, 0, 0, 1, 64'hB, 0);
    step(1, 0, 0, 1, 64'hC, 0);
    step(1, 0, 0, 1, 64'hC, 0);
    step(1, 0, 0, 1, 64'hC, 1);
    step(1, 0, 0, 1, 64'hC, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 64'h0, 1);

    // Hold while full with valid and ready high
    step(1, 0, 0, 1, 64'hA, 0);
    step(1, 0, 0, 1, 64'hB, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 64'hE, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 64'h0, 1);

    // Flush beats hold; 0xD offered in the flush cycle is dropped
    step(1, 0, 0, 1, 64'hA, 0);
    step(1, 0, 0, 1, 64'hB, 0);
    step(1, 1, 1, 1, 64'hD, 1);
    step(1, 0, 0, 1, 64'h6, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 64'h0, 1);

    // Reset mid-operation, then push 0x5
    step(1, 0, 0, 1, 64'h7, 0);
    step(0, 0, 0, 1, 64'h9, 1);
    step(1, 0, 0, 1, 64'h5, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 64'h0, 1);

    // Downstream ready toggling with upstream always valid
    for (int i = 0; i < 20; i++) step(1, 0, 0, 1, 64'h100 + 64'(i), i[0]);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 64'h0, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99) != 0, $urandom_range(99) < 3, $urandom_range(99) < 15,
           $urandom_range(99) < 70, {$urandom, $urandom}, $urandom_range(99) < 60);
    end
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 64'h0, 1);

    chk(1, "any_delivered", {63'd0, g_sb[1].delivered > 100}, 64'd1);
    chk(0, "any_delivered", {63'd0, g_sb[0].delivered > 100}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised inter-stage pipeline buffer that replaces the fixed-field EX/MEM-style registers between pipeline stages of the core. It carries an opaque payload of DATA_W bits under a valid/ready handshake, and honours the global hold and flush signals. In SKID mode it holds up to two entries, so upstream ready is a pure register output and no combinational path runs from downstream ready. Each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) instantiates one copy, with the stage's concatenated fields as payload.

## Interface
Parameters:
- DATA_W, 64 — payload width in bits (concatenated inst/ctrl/data fields of the stage)
- SKID, 1 — 1: two-entry skid buffer, registered in_ready_o; 0: single register, combinational in_ready_o
- NOP_VAL, all-zero — payload presented on out_data_o when the buffer is empty, after reset and after flush (each stage sets its own bubble, e.g. inst field 32'h0000_0013)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- hold_i  in  1  global pipeline stall; suppresses both push and pop this cycle
- flush_i  in  1  pipeline kill; discards all entries this cycle
- in_valid_i  in  1  upstream payload valid
- in_ready_o  out  1  buffer can accept
- in_data_i  in  DATA_W  upstream payload
- out_valid_o  out  1  head entry valid
- out_ready_i  in  1  downstream can accept
- out_data_o  out  DATA_W  head payload; NOP_VAL when empty
- count_o  out  2  occupancy, 0..2 (0..1 when SKID=0)

## Operation
- Fire conditions:
  - in_fire = in_valid_i & in_ready_o & !hold_i
  - out_fire = out_valid_o & out_ready_i & !hold_i
- Priority order: rst_n low > flush_i > hold_i > normal operation.
- Reset and flush behave identically:
  - state EMPTY, count_o=0, out_valid_o=0, out_data_o=NOP_VAL
  - in_ready_o=1 from the next cycle
  - flush_i overrides hold_i.
  - An in_valid_i present in the flush cycle is dropped.
- hold_i (no flush): all registers keep their values. Outputs stay stable; no entry is lost or duplicated.
- SKID=1 state machine. Entries are main (drives out_data_o) and skid.
  - EMPTY:
    - in_fire -> ONE, main<=in_data_i
  - ONE:
    - in_fire & !out_fire -> FULL, skid<=in_data_i
    - !in_fire & out_fire -> EMPTY, main<=NOP_VAL
    - both -> ONE, main<=in_data_i
    - neither -> ONE
  - FULL:
    - out_fire -> ONE, main<=skid
    - in_fire cannot occur because in_ready_o=0.
  - in_ready_o = (state != FULL), driven from a flop.
  - out_valid_o = (state != EMPTY), driven from a flop.
- SKID=0:
  - one entry; in_ready_o = !out_valid_o | (out_ready_i & !hold_i), combinational
  - Simultaneous in_fire/out_fire replaces the entry; out_fire alone loads NOP_VAL.
- Payload is never modified; widths are exact, with no truncation or extension.

## Timing
- Latency: in_fire in cycle N -> out_valid_o=1 with that payload in cycle N+1 (when empty, or when the head drains in N).
- Throughput: one transfer per cycle with out_ready_i held high, both modes.
- SKID=1: in_ready_o deasserts in the cycle after the second entry is captured. The skid entry absorbs the transfer accepted in that ready-high cycle.
- Ordering is strict FIFO; no bypass of the main entry by the skid entry.
- Flush in cycle N: out_valid_o=0 and count_o=0 in N+1. An in_fire in N+1 is accepted normally.
- Reset asserted mid-transfer behaves as flush. Outputs are at reset values in the cycle after the sampling edge.
- Outputs change only on clk edges, except SKID=0 in_ready_o.

## Structure
- Shared package pipe_pkg:
  - state typedef (EMPTY/ONE/FULL)
  - NOP_INST constant 32'h0000_0013
  - stage payload widths derived from defines.v buses (InstBus, RegBus, MemAddrBus, RegAddrBus)
- Sub-module pipe_skid_ctrl: state register, fire logic, in_ready_o/out_valid_o/count_o, and main/skid load selects.
- Top level holds only the two DATA_W payload registers and their muxes. With SKID=0 the skid register and FULL state are removed by generate.

## Test plan
- Streaming: SKID=1, DATA_W=64, out_ready_i=1, push 0x1..0x10 back-to-back -> out_data_o 0x1..0x10 on consecutive cycles, one cycle late, count_o=1 throughout.
- Backpressure: push 0xA, 0xB, 0xC with out_ready_i=0 -> count_o=2 and in_ready_o=0 after 0xB, 0xC held off. Release -> 0xA, 0xB, 0xC in order, no loss.
- Hold: FULL with 0xA/0xB, hold_i=1 for 3 cycles with in_valid_i and out_ready_i high -> outputs frozen, no fire. Release -> normal drain.
- Flush precedence: FULL, flush_i=1 with hold_i=1 and in_valid_i=1 (0xD) -> next cycle count_o=0, out_valid_o=0, out_data_o=NOP_VAL, 0xD never appears.
- Reset mid-operation: rst_n low for one edge while ONE -> all outputs at reset values, in_ready_o=1. Next push 0x5 appears after 1 cycle.
- SKID=0: out_ready_i toggling 1/0 each cycle with in_valid_i=1 -> in_ready_o follows out_ready_i combinationally while full, every value delivered exactly once.
